// File: rtl/mem_arbiter_if.sv
//------------------------------------------------------------------------------
// Module      : mem_arbiter_if
// Description : Bundle of the core-side (IF / LSQ) and RAM-side signals of the
//               byte-serial memory arbiter.
//               slave  : arbiter side (consumes requests, drives RAM bus)
//               master : core/RAM side (issues requests, supplies RAM data)
//               Signals: ena, in_rollback, IF request/response, LSQ
//               request/response, RAM byte bus (data in/out, addr, wr).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mem_arbiter_if #(
  parameter int RAM_ADDR_WIDTH = 32
);
  logic                      ena;
  logic                      in_rollback;
  // Instruction-fetch port
  logic                      in_if_ena;
  logic [31:0]               in_if_addr;
  logic                      out_if_ready;
  logic [31:0]               out_if_inst;
  // Load/store queue port
  logic                      in_ls_ena;
  logic                      in_ls_iswrite;
  logic [2:0]                in_ls_size;
  logic [31:0]               in_ls_addr;
  logic [31:0]               in_ls_write_data;
  logic                      out_ls_ready;
  logic [31:0]               out_ls_read_data;
  // Byte-wide RAM port
  logic [7:0]                in_ram_data;
  logic [7:0]                out_ram_data;
  logic [RAM_ADDR_WIDTH-1:0] out_ram_addr;
  logic                      out_ram_wr;

  modport slave (
    input  ena, in_rollback,
    input  in_if_ena, in_if_addr,
    output out_if_ready, out_if_inst,
    input  in_ls_ena, in_ls_iswrite, in_ls_size, in_ls_addr, in_ls_write_data,
    output out_ls_ready, out_ls_read_data,
    input  in_ram_data,
    output out_ram_data, out_ram_addr, out_ram_wr
  );

  modport master (
    output ena, in_rollback,
    output in_if_ena, in_if_addr,
    input  out_if_ready, out_if_inst,
    output in_ls_ena, in_ls_iswrite, in_ls_size, in_ls_addr, in_ls_write_data,
    input  out_ls_ready, out_ls_read_data,
    output in_ram_data,
    input  out_ram_data, out_ram_addr, out_ram_wr
  );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
//------------------------------------------------------------------------------
// Module      : mem_arbiter
// Description : Byte-serial memory controller between the core (LSQ and IF
//               ports) and a single-port byte-wide RAM. Each 1/2/4-byte
//               access is split into consecutive byte cycles; read bytes are
//               assembled little-endian. One-cycle ready pulse per request.
//               LSQ has priority over IF; rollback kills speculative reads.
// Ports       : clk, rst (async, active-high)
//               bus (mem_arbiter_if.slave): ena, in_rollback, IF req/resp,
//               LSQ req/resp, RAM byte bus.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_arbiter #(
  parameter int RAM_ADDR_WIDTH = 32
) (
  input  wire logic           clk,
  input  wire logic           rst,
  mem_arbiter_if.slave        bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t                    r_state;

  // Pending request slots, one per source
  logic                      r_if_pend;
  logic [31:0]               r_if_addr;
  logic                      r_ls_pend;
  logic                      r_ls_wr;
  logic [2:0]                r_ls_n;
  logic [31:0]               r_ls_addr;
  logic [31:0]               r_ls_wdata;

  // Access in progress
  logic                      r_src_ls;
  logic [31:0]               r_cur_addr;
  logic [2:0]                r_cur_n;
  logic [31:0]               r_cur_data;
  logic [2:0]                r_k;
  logic [31:0]               r_buf;

  // Registered outputs
  logic                      r_if_ready;
  logic [31:0]               r_if_inst;
  logic                      r_ls_ready;
  logic [31:0]               r_ls_rdata;
  logic [7:0]                r_ram_data;
  logic [RAM_ADDR_WIDTH-1:0] r_ram_addr;
  logic                      r_ram_wr;

  logic                      w_ls_take;
  logic                      w_if_take;
  logic [2:0]                w_req_n;
  logic [31:0]               w_byte_addr;
  logic [7:0]                w_wr_byte;
  logic [1:0]                w_rd_sh;
  logic [31:0]               w_rd_word;

  // A rollback cancels pending loads/fetches before they can be granted;
  // pending stores survive it.
  assign w_ls_take = r_ls_pend & (r_ls_wr | ~bus.in_rollback);
  assign w_if_take = r_if_pend & ~bus.in_rollback;

  always_comb begin
    w_req_n = 3'd4;
    case (bus.in_ls_size)
      3'd1:    w_req_n = 3'd1;
      3'd2:    w_req_n = 3'd2;
      default: w_req_n = 3'd4;
    endcase
  end

  // Address of byte k; wraps mod 2^32 before truncation to the RAM width.
  assign w_byte_addr = r_cur_addr + {29'd0, r_k};

  always_comb begin
    w_wr_byte = r_cur_data[7:0];
    case (r_k[1:0])
      2'd1:    w_wr_byte = r_cur_data[15:8];
      2'd2:    w_wr_byte = r_cur_data[23:16];
      2'd3:    w_wr_byte = r_cur_data[31:24];
      default: w_wr_byte = r_cur_data[7:0];
    endcase
  end

  // The byte arriving now belongs to lane k-1 (k=4 wraps to lane 3).
  // Lanes not yet captured are zero, so OR-merging assembles the word.
  assign w_rd_sh   = r_k[1:0] - 2'd1;
  assign w_rd_word = r_buf | ({24'd0, bus.in_ram_data} << {w_rd_sh, 3'b000});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_if_pend  <= 1'b0;
      r_if_addr  <= '0;
      r_ls_pend  <= 1'b0;
      r_ls_wr    <= 1'b0;
      r_ls_n     <= '0;
      r_ls_addr  <= '0;
      r_ls_wdata <= '0;
      r_src_ls   <= 1'b0;
      r_cur_addr <= '0;
      r_cur_n    <= '0;
      r_cur_data <= '0;
      r_k        <= '0;
      r_buf      <= '0;
      r_if_ready <= 1'b0;
      r_if_inst  <= '0;
      r_ls_ready <= 1'b0;
      r_ls_rdata <= '0;
      r_ram_data <= '0;
      r_ram_addr <= '0;
      r_ram_wr   <= 1'b0;
    end else if (bus.ena) begin
      r_if_ready <= 1'b0;
      r_ls_ready <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          r_ram_wr   <= 1'b0;
          r_ram_addr <= '0;
          if (w_ls_take) begin
            r_ls_pend  <= 1'b0;
            r_src_ls   <= 1'b1;
            r_cur_addr <= r_ls_addr;
            r_cur_n    <= r_ls_n;
            r_cur_data <= r_ls_wdata;
            r_k        <= 3'd1;
            r_buf      <= '0;
            r_ram_addr <= r_ls_addr[RAM_ADDR_WIDTH-1:0];
            if (r_ls_wr) begin
              r_state    <= ST_WRITE;
              r_ram_wr   <= 1'b1;
              r_ram_data <= r_ls_wdata[7:0];
            end else begin
              r_state    <= ST_READ;
            end
          end else if (w_if_take) begin
            r_if_pend  <= 1'b0;
            r_src_ls   <= 1'b0;
            r_cur_addr <= r_if_addr;
            r_cur_n    <= 3'd4;
            r_k        <= 3'd1;
            r_buf      <= '0;
            r_ram_addr <= r_if_addr[RAM_ADDR_WIDTH-1:0];
            r_state    <= ST_READ;
          end
        end

        ST_READ: begin
          if (bus.in_rollback) begin
            // Speculative read squashed, including one finishing this edge
            r_state    <= ST_IDLE;
            r_ram_addr <= '0;
          end else begin
            r_buf <= w_rd_word;
            if (r_k == r_cur_n) begin
              r_state    <= ST_IDLE;
              r_ram_addr <= '0;
              if (r_src_ls) begin
                r_ls_ready <= 1'b1;
                r_ls_rdata <= w_rd_word;
              end else begin
                r_if_ready <= 1'b1;
                r_if_inst  <= w_rd_word;
              end
            end else begin
              r_ram_addr <= w_byte_addr[RAM_ADDR_WIDTH-1:0];
              r_k        <= r_k + 3'd1;
            end
          end
        end

        ST_WRITE: begin
          if (r_k == r_cur_n) begin
            r_state    <= ST_IDLE;
            r_ram_wr   <= 1'b0;
            r_ram_addr <= '0;
            r_ls_ready <= 1'b1;
          end else begin
            r_ram_addr <= w_byte_addr[RAM_ADDR_WIDTH-1:0];
            r_ram_data <= w_wr_byte;
            r_k        <= r_k + 3'd1;
          end
        end

        default: begin
          r_state    <= ST_IDLE;
          r_ram_wr   <= 1'b0;
          r_ram_addr <= '0;
        end
      endcase

      // Slot maintenance comes after the grant so its effects take precedence.
      if (bus.in_rollback) begin
        r_if_pend <= 1'b0;
        if (!r_ls_wr) begin
          r_ls_pend <= 1'b0;
        end
      end

      if (bus.in_if_ena && !bus.in_rollback) begin
        r_if_pend <= 1'b1;
        r_if_addr <= bus.in_if_addr;
      end

      if (bus.in_ls_ena && (bus.in_ls_iswrite || !bus.in_rollback)) begin
        r_ls_pend  <= 1'b1;
        r_ls_wr    <= bus.in_ls_iswrite;
        r_ls_n     <= w_req_n;
        r_ls_addr  <= bus.in_ls_addr;
        r_ls_wdata <= bus.in_ls_write_data;
      end
    end
  end

  assign bus.out_if_ready     = r_if_ready;
  assign bus.out_if_inst      = r_if_inst;
  assign bus.out_ls_ready     = r_ls_ready;
  assign bus.out_ls_read_data = r_ls_rdata;
  assign bus.out_ram_data     = r_ram_data;
  assign bus.out_ram_addr     = r_ram_addr;
  assign bus.out_ram_wr       = r_ram_wr;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter. A small RAM
//               model answers reads combinationally from out_ram_addr and
//               logs every write strobe for later comparison.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [7:0]  mem [4096];
  logic [31:0] wa_q [$];
  logic [7:0]  wd_q [$];

  mem_arbiter_if #(.RAM_ADDR_WIDTH(32)) bus ();

  mem_arbiter #(.RAM_ADDR_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.in_ram_data = mem[bus.out_ram_addr[11:0]];

  always @(posedge clk) begin
    if (!rst && bus.ena && bus.out_ram_wr) begin
      wa_q.push_back(bus.out_ram_addr);
      wd_q.push_back(bus.out_ram_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_if(input logic [31:0] addr);
    bus.in_if_ena  = 1'b1;
    bus.in_if_addr = addr;
    step();
    bus.in_if_ena  = 1'b0;
  endtask

  task automatic issue_ls(input logic wr, input logic [2:0] size,
                          input logic [31:0] addr, input logic [31:0] data);
    bus.in_ls_ena        = 1'b1;
    bus.in_ls_iswrite    = wr;
    bus.in_ls_size       = size;
    bus.in_ls_addr       = addr;
    bus.in_ls_write_data = data;
    step();
    bus.in_ls_ena        = 1'b0;
  endtask

  task automatic test_reset();
    step();
    step();
    n_tests++; if (bus.out_if_ready !== 1'b0) begin n_fail++; $display("FAIL rst_if_ready: got %b want 0", bus.out_if_ready); end
    n_tests++; if (bus.out_ls_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ls_ready: got %b want 0", bus.out_ls_ready); end
    n_tests++; if (bus.out_if_inst !== 32'h0) begin n_fail++; $display("FAIL rst_if_inst: got %h want 0", bus.out_if_inst); end
    n_tests++; if (bus.out_ls_read_data !== 32'h0) begin n_fail++; $display("FAIL rst_ls_data: got %h want 0", bus.out_ls_read_data); end
    n_tests++; if (bus.out_ram_addr !== 32'h0 || bus.out_ram_wr !== 1'b0 || bus.out_ram_data !== 8'h0) begin
      n_fail++; $display("FAIL rst_ram: got addr %h wr %b data %h want 0 0 0", bus.out_ram_addr, bus.out_ram_wr, bus.out_ram_data); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_if_read();
    issue_if(32'h100);
    for (int j = 0; j < 4; j++) begin
      step();
      n_tests++; if (bus.out_ram_addr !== 32'h100 + j || bus.out_ram_wr !== 1'b0) begin
        n_fail++; $display("FAIL if_addr%0d: got %h wr %b want %h wr 0", j, bus.out_ram_addr, bus.out_ram_wr, 32'h100 + j); end
      n_tests++; if (bus.out_if_ready !== 1'b0) begin n_fail++; $display("FAIL if_early_ready%0d: got 1 want 0", j); end
    end
    step();
    n_tests++; if (bus.out_if_ready !== 1'b1 || bus.out_if_inst !== 32'h00000013) begin
      n_fail++; $display("FAIL if_done: got rdy %b inst %h want 1 00000013", bus.out_if_ready, bus.out_if_inst); end
    n_tests++; if (bus.out_ram_addr !== 32'h0) begin n_fail++; $display("FAIL if_idle_addr: got %h want 0", bus.out_ram_addr); end
    step();
    n_tests++; if (bus.out_if_ready !== 1'b0 || bus.out_if_inst !== 32'h00000013) begin
      n_fail++; $display("FAIL if_pulse_end: got rdy %b inst %h want 0 00000013", bus.out_if_ready, bus.out_if_inst); end
  endtask

  task automatic test_store_half();
    wa_q.delete(); wd_q.delete();
    issue_ls(1'b1, 3'd2, 32'h0001FFFE, 32'hAABBCCDD);
    step();
    n_tests++; if (bus.out_ram_addr !== 32'h1FFFE || bus.out_ram_data !== 8'hDD || bus.out_ram_wr !== 1'b1) begin
      n_fail++; $display("FAIL st_b0: got %h/%h/%b want 0001fffe/dd/1", bus.out_ram_addr, bus.out_ram_data, bus.out_ram_wr); end
    step();
    n_tests++; if (bus.out_ram_addr !== 32'h1FFFF || bus.out_ram_data !== 8'hCC || bus.out_ram_wr !== 1'b1) begin
      n_fail++; $display("FAIL st_b1: got %h/%h/%b want 0001ffff/cc/1", bus.out_ram_addr, bus.out_ram_data, bus.out_ram_wr); end
    step();
    n_tests++; if (bus.out_ram_wr !== 1'b0 || bus.out_ls_ready !== 1'b1 || bus.out_ram_addr !== 32'h0) begin
      n_fail++; $display("FAIL st_done: got wr %b rdy %b addr %h want 0 1 0", bus.out_ram_wr, bus.out_ls_ready, bus.out_ram_addr); end
    step();
    n_tests++; if (bus.out_ls_ready !== 1'b0) begin n_fail++; $display("FAIL st_pulse_end: got 1 want 0"); end
    n_tests++; if (wa_q.size() != 2 || wa_q[0] !== 32'h1FFFE || wd_q[0] !== 8'hDD || wa_q[1] !== 32'h1FFFF || wd_q[1] !== 8'hCC) begin
      n_fail++; $display("FAIL st_log: got %0d writes want 2 (1fffe:dd,1ffff:cc)", wa_q.size()); end
  endtask

  task automatic test_priority();
    bus.in_if_ena  = 1'b1;
    bus.in_if_addr = 32'h300;
    issue_ls(1'b0, 3'd1, 32'h20, 32'h0);
    bus.in_if_ena  = 1'b0;
    step();
    n_tests++; if (bus.out_ram_addr !== 32'h20) begin n_fail++; $display("FAIL pri_first: got %h want 00000020", bus.out_ram_addr); end
    step();
    n_tests++; if (bus.out_ls_ready !== 1'b1 || bus.out_ls_read_data !== 32'h5A || bus.out_if_ready !== 1'b0) begin
      n_fail++; $display("FAIL pri_ls_done: got rdy %b data %h ifrdy %b want 1 0000005a 0", bus.out_ls_ready, bus.out_ls_read_data, bus.out_if_ready); end
    step();
    n_tests++; if (bus.out_ram_addr !== 32'h300 || bus.out_ls_ready !== 1'b0) begin
      n_fail++; $display("FAIL pri_if_grant: got %h rdy %b want 00000300 0", bus.out_ram_addr, bus.out_ls_ready); end
    step(); step(); step(); step();
    n_tests++; if (bus.out_if_ready !== 1'b1 || bus.out_if_inst !== 32'h12345678) begin
      n_fail++; $display("FAIL pri_if_done: got rdy %b inst %h want 1 12345678", bus.out_if_ready, bus.out_if_inst); end
    step();
  endtask

  task automatic test_rollback_read();
    issue_if(32'h100);
    step(); step(); step();
    n_tests++; if (bus.out_ram_addr !== 32'h102) begin n_fail++; $display("FAIL rb_pre: got %h want 00000102", bus.out_ram_addr); end
    // Same-cycle IF request must be discarded by the rollback
    bus.in_rollback = 1'b1;
    bus.in_if_ena   = 1'b1;
    bus.in_if_addr  = 32'h300;
    step();
    bus.in_rollback = 1'b0;
    bus.in_if_ena   = 1'b0;
    n_tests++; if (bus.out_ram_addr !== 32'h0 || bus.out_if_ready !== 1'b0) begin
      n_fail++; $display("FAIL rb_abort: got addr %h rdy %b want 0 0", bus.out_ram_addr, bus.out_if_ready); end
    for (int i = 0; i < 6; i++) begin
      step();
      n_tests++; if (bus.out_if_ready !== 1'b0 || bus.out_ram_addr !== 32'h0) begin
        n_fail++; $display("FAIL rb_quiet%0d: got rdy %b addr %h want 0 0", i, bus.out_if_ready, bus.out_ram_addr); end
    end
    n_tests++; if (bus.out_if_inst !== 32'h12345678) begin n_fail++; $display("FAIL rb_hold: got %h want 12345678", bus.out_if_inst); end
    issue_if(32'h200);
    step();
    n_tests++; if (bus.out_ram_addr !== 32'h200) begin n_fail++; $display("FAIL rb_next_grant: got %h want 00000200", bus.out_ram_addr); end
    step(); step(); step(); step();
    n_tests++; if (bus.out_if_ready !== 1'b1 || bus.out_if_inst !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL rb_next_done: got rdy %b inst %h want 1 deadbeef", bus.out_if_ready, bus.out_if_inst); end
    step();
  endtask

  task automatic test_rollback_store();
    wa_q.delete(); wd_q.delete();
    issue_ls(1'b1, 3'd4, 32'h40, 32'h11223344);
    step();
    bus.in_rollback = 1'b1;
    step();
    bus.in_rollback = 1'b0;
    step(); step();
    n_tests++; if (bus.out_ram_addr !== 32'h43 || bus.out_ram_data !== 8'h11 || bus.out_ram_wr !== 1'b1) begin
      n_fail++; $display("FAIL rbst_b3: got %h/%h/%b want 00000043/11/1", bus.out_ram_addr, bus.out_ram_data, bus.out_ram_wr); end
    step();
    n_tests++; if (bus.out_ls_ready !== 1'b1 || bus.out_ram_wr !== 1'b0) begin
      n_fail++; $display("FAIL rbst_done: got rdy %b wr %b want 1 0", bus.out_ls_ready, bus.out_ram_wr); end
    n_tests++; if (wa_q.size() != 4 || wa_q[0] !== 32'h40 || wd_q[0] !== 8'h44 || wa_q[1] !== 32'h41 || wd_q[1] !== 8'h33 ||
                   wa_q[2] !== 32'h42 || wd_q[2] !== 8'h22 || wa_q[3] !== 32'h43 || wd_q[3] !== 8'h11) begin
      n_fail++; $display("FAIL rbst_log: got %0d writes want 4 (40:44,41:33,42:22,43:11)", wa_q.size()); end
    step();
  endtask

  task automatic test_stall_wrap();
    issue_ls(1'b0, 3'd1, 32'hFFFFFFFF, 32'h0);
    step();
    n_tests++; if (bus.out_ram_addr !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL stall_grant: got %h want ffffffff", bus.out_ram_addr); end
    bus.ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++; if (bus.out_ram_addr !== 32'hFFFFFFFF || bus.out_ls_ready !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold%0d: got addr %h rdy %b want ffffffff 0", i, bus.out_ram_addr, bus.out_ls_ready); end
    end
    bus.ena = 1'b1;
    step();
    n_tests++; if (bus.out_ls_ready !== 1'b1 || bus.out_ls_read_data !== 32'h000000C3) begin
      n_fail++; $display("FAIL stall_done: got rdy %b data %h want 1 000000c3", bus.out_ls_ready, bus.out_ls_read_data); end
    bus.ena = 1'b0;
    step(); step();
    n_tests++; if (bus.out_ls_ready !== 1'b1 || bus.out_ls_read_data !== 32'h000000C3) begin
      n_fail++; $display("FAIL stall_stretch: got rdy %b data %h want 1 000000c3", bus.out_ls_ready, bus.out_ls_read_data); end
    bus.ena = 1'b1;
    step();
    n_tests++; if (bus.out_ls_ready !== 1'b0) begin n_fail++; $display("FAIL stall_release: got 1 want 0"); end
    // Word load straddling the top of the address space
    issue_ls(1'b0, 3'd4, 32'hFFFFFFFE, 32'h0);
    step(); step(); step();
    n_tests++; if (bus.out_ram_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr: got %h want 00000000", bus.out_ram_addr); end
    step(); step();
    n_tests++; if (bus.out_ls_ready !== 1'b1 || bus.out_ls_read_data !== 32'h7E10C3A1) begin
      n_fail++; $display("FAIL wrap_done: got rdy %b data %h want 1 7e10c3a1", bus.out_ls_ready, bus.out_ls_read_data); end
    step();
  endtask

  task automatic test_async_reset();
    wa_q.delete(); wd_q.delete();
    issue_ls(1'b1, 3'd4, 32'h80, 32'hCAFEF00D);
    step(); step();
    #2 rst = 1'b1;
    #1;
    n_tests++; if (bus.out_ram_wr !== 1'b0 || bus.out_ram_addr !== 32'h0 || bus.out_ram_data !== 8'h0) begin
      n_fail++; $display("FAIL arst_now: got wr %b addr %h data %h want 0 0 0", bus.out_ram_wr, bus.out_ram_addr, bus.out_ram_data); end
    step();
    rst = 1'b0;
    wa_q.delete(); wd_q.delete();
    for (int i = 0; i < 6; i++) step();
    n_tests++; if (wa_q.size() != 0 || bus.out_ls_ready !== 1'b0) begin
      n_fail++; $display("FAIL arst_no_retry: got %0d writes rdy %b want 0 0", wa_q.size(), bus.out_ls_ready); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h100] = 8'h13;
    mem[12'h020] = 8'h5A;
    mem[12'h300] = 8'h78; mem[12'h301] = 8'h56; mem[12'h302] = 8'h34; mem[12'h303] = 8'h12;
    mem[12'h200] = 8'hEF; mem[12'h201] = 8'hBE; mem[12'h202] = 8'hAD; mem[12'h203] = 8'hDE;
    mem[12'hFFE] = 8'hA1; mem[12'hFFF] = 8'hC3; mem[12'h000] = 8'h10; mem[12'h001] = 8'h7E;

    bus.ena              = 1'b1;
    bus.in_rollback      = 1'b0;
    bus.in_if_ena        = 1'b0;
    bus.in_if_addr       = '0;
    bus.in_ls_ena        = 1'b0;
    bus.in_ls_iswrite    = 1'b0;
    bus.in_ls_size       = '0;
    bus.in_ls_addr       = '0;
    bus.in_ls_write_data = '0;

    test_reset();
    test_if_read();
    test_store_half();
    test_priority();
    test_rollback_read();
    test_rollback_store();
    test_stall_wrap();
    test_async_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1);
  end

endmodule

`default_nettype wire
